// File: rtl/riscv_misalign_split.sv
// Misaligned data access splitter between membuf and the data BIU.
// Macro RISCV_MISALIGN_SPLIT_EN enables byte-beat splitting; otherwise misaligned accesses are rejected.
package riscv_misalign_split_pkg;
    typedef enum logic [1:0] {
        BYTE  = 2'd0,
        HWORD = 2'd1,
        WORD  = 2'd2,
        DWORD = 2'd3
    } biu_size_t;

    typedef logic [2:0] biu_prot_t;
endpackage

module riscv_misalign_split
    import riscv_misalign_split_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic            req_i,
    input  logic [XLEN-1:0] adr_i,
    input  biu_size_t       size_i,
    input  logic            lock_i,
    input  biu_prot_t       prot_i,
    input  logic            we_i,
    input  logic [XLEN-1:0] d_i,
    output logic            ack_o,
    output logic [XLEN-1:0] q_o,
    output logic            err_o,
    output logic            misaligned_o,
    output logic            busy_o,
    output logic            req_o,
    input  logic            ack_i,
    output logic [XLEN-1:0] adr_o,
    output biu_size_t       size_o,
    output logic            lock_o,
    output biu_prot_t       prot_o,
    output logic            we_o,
    output logic [XLEN-1:0] d_o,
    input  logic [XLEN-1:0] q_i,
    input  logic            err_i
);

    localparam int LB = (XLEN == 64) ? 3 : 2;

    function automatic logic is_misaligned(
        input biu_size_t  s,
        input logic [2:0] a
    );
        logic m;
        m = 1'b0;
        case (s)
            BYTE:    m = 1'b0;
            HWORD:   m = a[0];
            WORD:    m = |a[1:0];
            DWORD:   m = (XLEN == 64) && (|a);
            default: m = 1'b0;
        endcase
        return m;
    endfunction

    logic mis;
    assign mis = req_i && is_misaligned(size_i, adr_i[2:0]);

`ifdef RISCV_MISALIGN_SPLIT_EN

    typedef enum logic [1:0] {
        IDLE,
        SPLIT,
        DRAIN
    } state_t;

    function automatic logic [2:0] last_beat(input biu_size_t s);
        logic [2:0] r;
        r = 3'd0;
        case (s)
            HWORD:   r = 3'd1;
            WORD:    r = 3'd3;
            DWORD:   r = 3'd7;
            default: r = 3'd0;
        endcase
        return r;
    endfunction

    state_t          state_q, state_d;
    logic [2:0]      cnt_q, cnt_d;
    logic [XLEN-1:0] qbuf_q, qbuf_d;
    logic [XLEN-1:0] adr_lat, d_lat;
    biu_size_t       size_lat;
    biu_prot_t       prot_lat;
    logic            we_lat;
    logic            latch;
    logic [XLEN-1:0] beat_adr;
    logic [XLEN-1:0] q_merge;
    logic [LB-1:0]   lane;
    logic            last;

    assign beat_adr = adr_lat + XLEN'(cnt_q);
    assign lane     = beat_adr[LB-1:0];
    assign last     = (cnt_q == last_beat(size_lat));

    // buffered bytes plus the byte arriving on this beat
    always_comb begin
        q_merge = qbuf_q;
        q_merge[{lane, 3'b000} +: 8] = q_i[{lane, 3'b000} +: 8];
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        qbuf_d       = qbuf_q;
        latch        = 1'b0;
        req_o        = req_i;
        adr_o        = adr_i;
        size_o       = size_i;
        lock_o       = lock_i;
        prot_o       = prot_i;
        we_o         = we_i;
        d_o          = d_i;
        ack_o        = ack_i;
        q_o          = q_i;
        err_o        = err_i;
        misaligned_o = 1'b0;
        busy_o       = (state_q != IDLE);

        unique case (state_q)
            IDLE: begin
                if (mis) begin
                    req_o   = 1'b0;
                    ack_o   = 1'b0;
                    err_o   = 1'b0;
                    latch   = 1'b1;
                    cnt_d   = 3'd0;
                    qbuf_d  = '0;
                    state_d = SPLIT;
                end
            end
            SPLIT, DRAIN: begin
                req_o  = 1'b1;
                adr_o  = beat_adr;
                size_o = BYTE;
                lock_o = 1'b1;
                prot_o = prot_lat;
                we_o   = we_lat;
                d_o    = d_lat;
                ack_o  = 1'b0;
                err_o  = 1'b0;
                q_o    = q_merge;
                if (state_q == DRAIN) begin
                    if (ack_i) state_d = IDLE;
                end else if (ack_i) begin
                    if (!we_lat) qbuf_d = q_merge;
                    if (flush_i) begin
                        state_d = IDLE;
                    end else if (err_i || last) begin
                        ack_o   = 1'b1;
                        err_o   = err_i;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end else if (flush_i) begin
                    state_d = DRAIN;
                end
            end
            default: state_d = IDLE;
        endcase

        if (rst_i) begin
            req_o        = 1'b0;
            ack_o        = 1'b0;
            err_o        = 1'b0;
            misaligned_o = 1'b0;
            busy_o       = 1'b0;
            adr_o        = adr_i;
            size_o       = size_i;
            lock_o       = lock_i;
            prot_o       = prot_i;
            we_o         = we_i;
            d_o          = d_i;
            q_o          = q_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            qbuf_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            qbuf_q  <= qbuf_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (latch) begin
            adr_lat  <= adr_i;
            size_lat <= size_i;
            we_lat   <= we_i;
            d_lat    <= d_i;
            prot_lat <= prot_i;
        end
    end

`else

    // no sequencing state in this build
    logic unused_in;
    assign unused_in = ^{clk_i, flush_i};

    always_comb begin
        req_o        = req_i;
        adr_o        = adr_i;
        size_o       = size_i;
        lock_o       = lock_i;
        prot_o       = prot_i;
        we_o         = we_i;
        d_o          = d_i;
        ack_o        = ack_i;
        q_o          = q_i;
        err_o        = err_i;
        misaligned_o = 1'b0;
        busy_o       = 1'b0;
        if (mis) begin
            req_o        = 1'b0;
            ack_o        = 1'b1;
            misaligned_o = 1'b1;
            q_o          = '0;
            err_o        = 1'b0;
        end
        if (rst_i) begin
            req_o        = 1'b0;
            ack_o        = 1'b0;
            err_o        = 1'b0;
            misaligned_o = 1'b0;
            q_o          = q_i;
        end
    end

`endif

endmodule
